// File: rtl/reset_seq_pkg.sv
// Shared types for the ordered reset-release controller: sequencer state
// encoding and the stage-index width helper.
package reset_seq_pkg;

   typedef enum logic [2:0] {
      ST_ASSERT,
      ST_RELEASE,
      ST_WAIT,
      ST_RUN,
      ST_FAULT
   } seq_state_t;

   // A single stage still needs a one-bit index.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ready_sync.sv
// Vector two-flop synchronizer with asynchronous clear, used to bring the
// per-stage ready/lock indications into the clk domain.
module ready_sync #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             clr,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/reset_sequencer.sv
// Ordered reset-release controller: holds all stages in reset, then releases
// them one by one, waiting for each stage's ready with a timeout.
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter  int N_STAGES       = 4,
   parameter  int HOLD_CYCLES    = 16,
   parameter  int TIMEOUT_CYCLES = 1024,
   localparam int KW             = idx_width(N_STAGES)
) (
   input  logic                clk,
   input  logic                initial_reset_i,
   input  logic                soft_reset_req_i,
   input  logic [N_STAGES-1:0] stage_ready_i,
   output logic [N_STAGES-1:0] stage_reset_o,
   output logic                busy_o,
   output logic                done_o,
   output logic                timeout_o,
   output logic [KW-1:0]       fault_stage_o
);

   localparam int HW = $clog2(HOLD_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
   localparam logic [TW-1:0] TO_MAX    = TW'(TIMEOUT_CYCLES);
   localparam logic [KW-1:0] K_LAST    = KW'(N_STAGES - 1);

   seq_state_t          state_q, state_d;
   logic [KW-1:0]       k_q, k_d;
   logic [HW-1:0]       hold_q, hold_d;
   logic [TW-1:0]       to_q, to_d;
   logic [N_STAGES-1:0] rdy_s;
   logic [N_STAGES-1:0] rst_d;
   logic                busy_d, done_d, timeout_d;
   logic [KW-1:0]       fault_d;
   logic                lost;
   logic [KW-1:0]       lost_idx;

   // Reset mask covering stage s and every stage above it.
   function automatic logic [N_STAGES-1:0] from_stage(input logic [KW-1:0] s);
      return {N_STAGES{1'b1}} << s;
   endfunction

   ready_sync #(.WIDTH(N_STAGES)) u_ready_sync (
      .clk (clk),
      .clr (initial_reset_i),
      .d   (stage_ready_i),
      .q   (rdy_s)
   );

   // Lowest stage that has dropped ready.
   always_comb begin
      lost     = 1'b0;
      lost_idx = '0;
      for (int i = N_STAGES - 1; i >= 0; i--) begin
         if (!rdy_s[i]) begin
            lost     = 1'b1;
            lost_idx = KW'(i);
         end
      end
   end

   always_ff @(posedge clk or posedge initial_reset_i) begin
      if (initial_reset_i) begin
         state_q       <= ST_ASSERT;
         k_q           <= '0;
         hold_q        <= '0;
         to_q          <= '0;
         stage_reset_o <= '1;
         busy_o        <= 1'b1;
         done_o        <= 1'b0;
         timeout_o     <= 1'b0;
         fault_stage_o <= '0;
      end else begin
         state_q       <= state_d;
         k_q           <= k_d;
         hold_q        <= hold_d;
         to_q          <= to_d;
         stage_reset_o <= rst_d;
         busy_o        <= busy_d;
         done_o        <= done_d;
         timeout_o     <= timeout_d;
         fault_stage_o <= fault_d;
      end
   end

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      hold_d  = hold_q;
      to_d    = to_q;
      if (soft_reset_req_i) begin
         state_d = ST_ASSERT;
         k_d     = '0;
         hold_d  = '0;
      end else begin
         case (state_q)
            ST_ASSERT: begin
               if (hold_q >= HOLD_LAST) state_d = ST_RELEASE;
               else                     hold_d  = hold_q + 1'b1;
            end
            ST_RELEASE: begin
               to_d    = '0;
               state_d = ST_WAIT;
            end
            ST_WAIT: begin
               // Ready is tested first so it wins a tie with the timeout limit.
               if (rdy_s[k_q]) begin
                  if (k_q == K_LAST) begin
                     state_d = ST_RUN;
                  end else begin
                     k_d     = k_q + 1'b1;
                     state_d = ST_RELEASE;
                  end
               end else if (to_q == TO_MAX) begin
                  state_d = ST_FAULT;
               end else begin
                  to_d = to_q + 1'b1;
               end
            end
            ST_RUN: begin
               if (lost) begin
                  state_d = ST_ASSERT;
                  k_d     = lost_idx;
                  hold_d  = '0;
               end
            end
            ST_FAULT: ;
            default:  state_d = ST_ASSERT;
         endcase
      end
   end

   always_comb begin
      rst_d     = stage_reset_o;
      timeout_d = timeout_o;
      fault_d   = fault_stage_o;
      if (soft_reset_req_i) begin
         rst_d     = '1;
         timeout_d = 1'b0;
      end else begin
         case (state_q)
            ST_ASSERT:  rst_d = stage_reset_o | from_stage(k_q);
            ST_RELEASE: rst_d[k_q] = 1'b0;
            ST_WAIT: begin
               if (state_d == ST_FAULT) begin
                  rst_d     = stage_reset_o | from_stage(k_q);
                  timeout_d = 1'b1;
                  fault_d   = k_q;
               end
            end
            ST_RUN: begin
               if (state_d == ST_ASSERT) begin
                  rst_d   = stage_reset_o | from_stage(lost_idx);
                  fault_d = lost_idx;
               end
            end
            ST_FAULT:   rst_d = stage_reset_o | from_stage(fault_stage_o);
            default:    rst_d = '1;
         endcase
      end
      busy_d = !(state_d inside {ST_RUN, ST_FAULT});
      done_d = (state_d == ST_RUN);
   end

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: directed scenarios with literal
// timing expectations, then randomized traffic against a behavioural model.
module tb_reset_sequencer;

   localparam int N = 3;
   localparam int H = 8;
   localparam int T = 32;

   localparam int PH_HOLD  = 0;
   localparam int PH_REL   = 1;
   localparam int PH_WAIT  = 2;
   localparam int PH_RUN   = 3;
   localparam int PH_FAULT = 4;

   logic         clk = 1'b0;
   logic         initial_reset_i = 1'b1;
   logic         soft_reset_req_i = 1'b0;
   logic [N-1:0] stage_ready_i = '0;
   logic [N-1:0] stage_reset_o;
   logic         busy_o, done_o, timeout_o;
   logic [1:0]   fault_stage_o;

   int checks = 0;
   int errors = 0;

   // model state
   int           m_phase, m_ptr, m_hold, m_age, m_flt, cyc;
   bit           m_to;
   logic [N-1:0] m_rst, m_s1, m_s2;

   reset_sequencer #(.N_STAGES(N), .HOLD_CYCLES(H), .TIMEOUT_CYCLES(T)) dut (
      .clk              (clk),
      .initial_reset_i  (initial_reset_i),
      .soft_reset_req_i (soft_reset_req_i),
      .stage_ready_i    (stage_ready_i),
      .stage_reset_o    (stage_reset_o),
      .busy_o           (busy_o),
      .done_o           (done_o),
      .timeout_o        (timeout_o),
      .fault_stage_o    (fault_stage_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [N-1:0] upper(input int s);
      logic [N-1:0] m;
      for (int i = 0; i < N; i++) m[i] = (i >= s);
      return m;
   endfunction

   task automatic model_reset();
      m_phase = PH_HOLD; m_ptr = 0; m_hold = H; m_age = 0;
      m_flt = 0; m_to = 0; m_rst = '1; m_s1 = '0; m_s2 = '0; cyc = 0;
   endtask

   task automatic model_step();
      logic [N-1:0] seen;
      int           j;
      seen = m_s2;
      m_s2 = m_s1;
      m_s1 = stage_ready_i;
      cyc++;
      if (soft_reset_req_i) begin
         m_phase = PH_HOLD; m_ptr = 0; m_hold = H; m_rst = '1; m_to = 0;
      end else begin
         case (m_phase)
            PH_HOLD: begin
               m_rst  = m_rst | upper(m_ptr);
               m_hold = m_hold - 1;
               if (m_hold == 0) m_phase = PH_REL;
            end
            PH_REL: begin
               m_rst[m_ptr] = 1'b0;
               m_age = 0;
               m_phase = PH_WAIT;
            end
            PH_WAIT: begin
               if (seen[m_ptr]) begin
                  if (m_ptr == N - 1) m_phase = PH_RUN;
                  else begin m_ptr++; m_phase = PH_REL; end
               end else if (m_age == T) begin
                  m_phase = PH_FAULT; m_flt = m_ptr; m_to = 1;
                  m_rst = m_rst | upper(m_ptr);
               end else m_age++;
            end
            PH_RUN: begin
               j = -1;
               for (int i = 0; i < N; i++) if (!seen[i] && j < 0) j = i;
               if (j >= 0) begin
                  m_flt = j; m_ptr = j; m_phase = PH_HOLD; m_hold = H;
                  m_rst = m_rst | upper(j);
               end
            end
            default: ;
         endcase
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or posedge initial_reset_i);
         if (initial_reset_i) model_reset();
         else model_step();
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         chk("stage_reset", 32'(stage_reset_o), 32'(m_rst));
         chk("busy", 32'(busy_o), 32'(m_phase != PH_RUN && m_phase != PH_FAULT));
         chk("done", 32'(done_o), 32'(m_phase == PH_RUN));
         chk("timeout", 32'(timeout_o), 32'(m_to));
         chk("fault_stage", 32'(fault_stage_o), 32'(m_flt));
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_fall(input int b, output int at);
      int n = 0;
      while (stage_reset_o[b] && n < 300) begin step(); n++; end
      chk("fall_reached", 32'(stage_reset_o[b]), 32'd0);
      at = cyc;
   endtask

   task automatic wait_done(output int at);
      int n = 0;
      while (!done_o && n < 300) begin step(); n++; end
      chk("done_reached", 32'(done_o), 32'd1);
      at = cyc;
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_rst"}, 32'(stage_reset_o), 32'h7);
      chk({tag, "_busy"}, 32'(busy_o), 32'd1);
      chk({tag, "_done"}, 32'(done_o), 32'd0);
      chk({tag, "_timeout"}, 32'(timeout_o), 32'd0);
      chk({tag, "_fault"}, 32'(fault_stage_o), 32'd0);
   endtask

   initial begin
      int f0, f1, f2, d, ft, dcyc, n;
      repeat (3) step();
      check_reset_values("por");
      #1 initial_reset_i = 1'b0;

      // nominal sequence
      wait_fall(0, f0);
      chk("rel0_edge", 32'(f0), 32'd9);
      repeat (5) step();
      #1 stage_ready_i[0] = 1'b1;
      wait_fall(1, f1);
      chk("rel1_edge", 32'(f1), 32'd18);
      repeat (5) step();
      #1 stage_ready_i[1] = 1'b1;
      wait_fall(2, f2);
      chk("rel2_edge", 32'(f2), 32'd27);
      repeat (5) step();
      #1 stage_ready_i[2] = 1'b1;
      wait_done(d);
      chk("done_edge", 32'(d), 32'd35);
      chk("run_busy", 32'(busy_o), 32'd0);

      // one-cycle ready loss on stage 1 while running
      step();
      dcyc = cyc;
      #1 stage_ready_i[1] = 1'b0;
      step();
      #1 stage_ready_i[1] = 1'b1;
      step();
      step();
      chk("loss_rst", 32'(stage_reset_o), 32'h6);
      chk("loss_done", 32'(done_o), 32'd0);
      chk("loss_fault", 32'(fault_stage_o), 32'd1);
      wait_fall(1, f1);
      chk("loss_rel1", 32'(f1 - dcyc), 32'd12);
      wait_done(d);
      chk("loss_done_edge", 32'(d - dcyc), 32'd15);
      chk("loss_rst_run", 32'(stage_reset_o), 32'h0);

      // timeout on stage 1
      #1 stage_ready_i = '0; soft_reset_req_i = 1'b1;
      step();
      #1 soft_reset_req_i = 1'b0;
      wait_fall(0, f0);
      repeat (5) step();
      #1 stage_ready_i[0] = 1'b1;
      wait_fall(1, f1);
      n = 0;
      while (!timeout_o && n < 100) begin step(); n++; end
      ft = cyc;
      chk("to_reached", 32'(timeout_o), 32'd1);
      chk("to_edge", 32'(ft - f1), 32'd33);
      chk("to_fault", 32'(fault_stage_o), 32'd1);
      chk("to_rst", 32'(stage_reset_o), 32'h6);
      repeat (10) step();
      chk("to_rst_held", 32'(stage_reset_o), 32'h6);
      chk("to_sticky", 32'(timeout_o), 32'd1);

      // soft reset from FAULT
      #1 stage_ready_i = '1; soft_reset_req_i = 1'b1;
      step();
      chk("soft_f_rst", 32'(stage_reset_o), 32'h7);
      chk("soft_f_to", 32'(timeout_o), 32'd0);
      #1 soft_reset_req_i = 1'b0;
      wait_done(d);
      chk("soft_f_rst_run", 32'(stage_reset_o), 32'h0);

      // soft reset in the middle of stage 2's wait
      #1 stage_ready_i = 3'b011; soft_reset_req_i = 1'b1;
      step();
      #1 soft_reset_req_i = 1'b0;
      wait_fall(2, f2);
      repeat (4) step();
      #1 soft_reset_req_i = 1'b1;
      step();
      chk("soft_w_rst", 32'(stage_reset_o), 32'h7);
      chk("soft_w_busy", 32'(busy_o), 32'd1);

      // ready arriving on the same cycle the timeout limit is reached
      #1 soft_reset_req_i = 1'b0; stage_ready_i = 3'b001;
      wait_fall(1, f1);
      n = 0;
      while (cyc < f1 + 30 && n < 100) begin step(); n++; end
      #1 stage_ready_i[1] = 1'b1;
      wait_fall(2, f2);
      chk("race_rel2", 32'(f2 - f1), 32'd34);
      chk("race_no_to", 32'(timeout_o), 32'd0);

      // asynchronous reset between edges during stage 2's wait
      step();
      #2 initial_reset_i = 1'b1;
      #1 check_reset_values("async");
      step();
      step();
      #1 initial_reset_i = 1'b0;

      // randomized traffic
      for (int c = 0; c < 4000; c++) begin
         step();
         #1;
         for (int i = 0; i < N; i++) begin
            if (!stage_ready_i[i]) begin
               if ($urandom_range(0, 7) == 0) stage_ready_i[i] = 1'b1;
            end else if ($urandom_range(0, 59) == 0) stage_ready_i[i] = 1'b0;
         end
         soft_reset_req_i = ($urandom_range(0, 249) == 0);
         if (!initial_reset_i && $urandom_range(0, 1499) == 0) initial_reset_i = 1'b1;
         else initial_reset_i = 1'b0;
      end
      step();
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Ordered reset-release controller for the SDR FPGA's reset tree. It sits downstream of the power-on reset generator and takes its `initial_reset_o` as the block reset and its software reset bit as a restart request. It holds N dependent subsystems in reset, for example the clock/PLL, the ADC/DAC interface, the DSP chain and the host FIFO. It then releases them one at a time, waiting after each release for that stage's ready/lock indication before moving to the next. Each wait has a timeout, and the block re-sequences a stage if that stage loses ready during normal operation.

## Interface
- `N_STAGES`, 4, number of sequenced stages; stage 0 is released first; 1..8.
- `HOLD_CYCLES`, 16, cycles all resets are held in `ASSERT` before stage 0 is released; ≥1.
- `TIMEOUT_CYCLES`, 1024, maximum cycles to wait for a stage's synchronized ready; ≥4.
- `clk` input 1: single clock; all logic on the rising edge.
- `initial_reset_i` input 1: asynchronous, active-high block reset.
- `soft_reset_req_i` input 1: synchronous restart request, level-sensitive; while high it forces `ASSERT`.
- `stage_ready_i` input N_STAGES: per-stage ready/lock; asynchronous to `clk`.
- `stage_reset_o` output N_STAGES: per-stage reset, active-high, registered.
- `busy_o` output 1: sequence in progress (any state except `RUN` and `FAULT`).
- `done_o` output 1: all stages released and ready (state `RUN`).
- `timeout_o` output 1: sticky fault flag, high in `FAULT`.
- `fault_stage_o` output $clog2(N_STAGES) (minimum width 1): index of the stage that timed out or lost ready; holds its last value.

## Operation
- `stage_ready_i` passes through a 2-flop synchronizer; the FSM uses only the synchronized `rdy_s`.
- Stage pointer `k` has width $clog2(N_STAGES) (minimum 1). The hold counter and the timeout counter are sized to their parameters and saturate rather than wrap.
- **ASSERT** (entered with `k` = start stage `s`):
  - `stage_reset_o[j]` = 1 for every j ≥ s; stages j < s keep their current value.
  - The hold counter runs.
  - After `HOLD_CYCLES` cycles the FSM goes to RELEASE.
- **RELEASE**:
  - Clear `stage_reset_o[k]`.
  - Clear the timeout counter.
  - Go to WAIT.
- **WAIT**: compare the timeout counter against `TIMEOUT_CYCLES` on every cycle.
  - If `rdy_s[k]` = 1 and k = N_STAGES−1, go to RUN.
  - If `rdy_s[k]` = 1 and k < N_STAGES−1, increment k and go to RELEASE.
  - If the counter reaches `TIMEOUT_CYCLES` first, go to FAULT and load `fault_stage_o` = k.
- **RUN**: monitor `rdy_s[0..N−1]` on every cycle.
  - A 0 on any bit means ready was lost.
  - Let j be the lowest such index; load `fault_stage_o` = j.
  - Go to ASSERT with s = j. Stages below j stay released.
- **FAULT**:
  - Stages ≥ `fault_stage_o` stay in reset; `timeout_o` = 1.
  - The FSM stays here until `soft_reset_req_i` is asserted.
- **soft_reset_req_i**:
  - Highest priority, in any state.
  - Next state is ASSERT with s = 0, so all resets go to 1.
  - `timeout_o` clears on that edge.
  - The hold count restarts for every cycle the request stays high.
- **Simultaneous events**:
  - Ready and the timeout limit in the same cycle: ready wins.
  - Soft request together with anything: the soft request wins.
- `initial_reset_i` asserted mid-sequence:
  - Immediate asynchronous return to the reset values.
  - The synchronizer flops clear to 0.

## Timing
- **Reset values**:
  - `stage_reset_o` = all 1s, `busy_o` = 1.
  - `done_o` = 0, `timeout_o` = 0, `fault_stage_o` = 0.
  - State = ASSERT, k = 0.
- **Release of stage 0**: `stage_reset_o[0]` falls on the (HOLD_CYCLES+1)th rising edge after `initial_reset_i` deasserts.
- **Stage-to-stage latency**: the edge on which `stage_reset_o[k]` falls is the reference edge.
  - `stage_ready_i[k]` rises at least 1 cycle after the reference edge.
  - `rdy_s` sees it 2 edges later.
  - `stage_reset_o[k+1]` falls 2 edges after `rdy_s[k]` is seen (WAIT→RELEASE, then RELEASE).
- **Timeout**: FAULT is entered `TIMEOUT_CYCLES`+1 edges after the RELEASE edge of stage k if `rdy_s[k]` never rises.
- **Flag timing**: `done_o` and `busy_o` are registered and change on the same edge as the state.
- **Ready loss in RUN**:
  - Reset reasserts 3 edges after the `stage_ready_i` drop: 2 synchronizer edges plus 1 FSM edge.
  - `done_o` falls on that same edge.

## Structure
- `reset_seq_pkg`: the state enum (ASSERT, RELEASE, WAIT, RUN, FAULT) and the stage-index width function.
- Sub-module `ready_sync`: parameterized vector 2-flop synchronizer with asynchronous clear, instanced once for `stage_ready_i`.
- Everything else lives in a single FSM module.

## Test plan
All scenarios use N_STAGES=3, HOLD_CYCLES=8, TIMEOUT_CYCLES=32.
1. **Nominal sequence**:
   - Stimulus: release `initial_reset_i`; raise each `stage_ready_i[k]` 5 cycles after its reset falls.
   - Response: `stage_reset_o[0]` falls at edge 9; stages 1 and 2 follow in order; `done_o` = 1 and `busy_o` = 0 after stage 2 is ready.
2. **Timeout**:
   - Stimulus: hold `stage_ready_i[1]` = 0.
   - Response: FAULT 33 edges after stage 1 is released; `timeout_o` = 1; `fault_stage_o` = 1; `stage_reset_o` = 3'b110 held.
3. **Ready loss in RUN**:
   - Stimulus: in RUN, drop `stage_ready_i[1]` for 1 cycle, then restore it.
   - Response: `stage_reset_o` = 3'b110 and `done_o` = 0; after 8 hold cycles stages 1 then 2 are re-released; stage 0 never resets.
4. **Soft reset**:
   - Stimulus: pulse `soft_reset_req_i` in FAULT, and separately in mid-WAIT of stage 2.
   - Response: both cases give all resets = 1 and `timeout_o` = 0, then a full re-sequence from stage 0.
5. **Asynchronous reset mid-sequence**:
   - Stimulus: assert `initial_reset_i` between clock edges during WAIT.
   - Response: outputs take their reset values immediately, without waiting for a clock edge.
6. **Ready/timeout race**:
   - Stimulus: `rdy_s[k]` rises on the same cycle the timeout counter reaches 32.
   - Response: the sequence advances; no FAULT.
